// File: rtl/iob_cache_req_pipe_pkg.sv
// Shared sizing helpers and default configuration for the iob_cache request pipe.
// Latency: n/a (compile-time constants and constant functions only).
// Backpressure: n/a.
package iob_cache_req_pipe_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DEPTH_W = 1;

    // Number of byte strobes for a given data width.
    function automatic int nbytes(input int data_w);
        return data_w / 8;
    endfunction

    // Word-address width: byte address with the intra-word offset bits dropped.
    function automatic int waddr_w(input int addr_w, input int data_w);
        return addr_w - $clog2(data_w / 8);
    endfunction

    // Width of one queued request, packed as {addr, wdata, wstrb}.
    function automatic int req_w(input int addr_w, input int data_w);
        return waddr_w(addr_w, data_w) + data_w + nbytes(data_w);
    endfunction

    // Bit offsets of each field inside a packed request entry.
    function automatic int strb_lsb();
        return 0;
    endfunction

    function automatic int wdata_lsb(input int data_w);
        return nbytes(data_w);
    endfunction

    function automatic int addr_lsb(input int data_w);
        return nbytes(data_w) + data_w;
    endfunction

endpackage

// File: rtl/iob_cache_req_pipe_if.sv
// CPU-side request/response and cache-side native bus of the request pipe, bundled.
// Latency: n/a (wires only).
// Backpressure: req_ready towards the CPU, ready from the cache.
interface iob_cache_req_pipe_if
    import iob_cache_req_pipe_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int WADDR_W = waddr_w(ADDR_W, DATA_W);
    localparam int NBYTES  = nbytes(DATA_W);

    // CPU request channel
    logic               req_valid;
    logic               req_ready;
    logic [WADDR_W-1:0] req_addr;
    logic [DATA_W-1:0]  req_wdata;
    logic [NBYTES-1:0]  req_wstrb;

    // CPU completion channel
    logic               resp_valid;
    logic [DATA_W-1:0]  resp_rdata;
    logic               resp_we;
    logic               busy;

    // Cache native front-end
    logic               valid;
    logic [WADDR_W-1:0] addr;
    logic [DATA_W-1:0]  wdata;
    logic [NBYTES-1:0]  wstrb;
    logic [DATA_W-1:0]  rdata;
    logic               ready;

    // Environment view: CPU drives requests, cache drives rdata/ready.
    modport master (
        output req_valid, req_addr, req_wdata, req_wstrb, rdata, ready,
        input  req_ready, resp_valid, resp_rdata, resp_we, busy,
               valid, addr, wdata, wstrb
    );

    // Pipe view.
    modport slave (
        input  req_valid, req_addr, req_wdata, req_wstrb, rdata, ready,
        output req_ready, resp_valid, resp_rdata, resp_we, busy,
               valid, addr, wdata, wstrb
    );

endinterface

// File: rtl/iob_cache_req_pipe_fifo.sv
// Register FIFO of 2**DEPTH_W entries with first-word fall-through head.
// Latency: pushed entry visible at dout_o the cycle after push when empty.
// Backpressure: full_o blocks push; push while full / pop while empty are ignored.
module iob_cache_req_fifo #(
    parameter int WIDTH   = 8,
    parameter int DEPTH_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned     DEPTH    = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // Next pointers wrap naturally at DEPTH; count moves only on unbalanced push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (DEPTH_W + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head never shows X towards the cache.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/iob_cache_req_pipe.sv
// In-order CPU request buffer in front of iob_cache; returns completions in issue order.
// Latency: push->valid 1 cycle; completion same cycle as ready (+1 with IOB_CACHE_REQ_PIPE_RESP_REG_EN).
// Backpressure: req_ready = FIFO not full (registered state only, a same-cycle pop does not free a slot).
module iob_cache_req_pipe
    import iob_cache_req_pipe_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH_W = DEF_DEPTH_W
) (
    input  logic                 clk,
    input  logic                 reset,
    iob_cache_req_pipe_if.slave  bus
);
    localparam int WADDR_W   = waddr_w(ADDR_W, DATA_W);
    localparam int NBYTES    = nbytes(DATA_W);
    localparam int REQ_W     = req_w(ADDR_W, DATA_W);
    localparam int STRB_LSB  = strb_lsb();
    localparam int WDATA_LSB = wdata_lsb(DATA_W);
    localparam int ADDR_LSB  = addr_lsb(DATA_W);

    logic               push, pop;
    logic               fifo_full, fifo_empty;
    logic [REQ_W-1:0]   entry_in, head;
    logic [NBYTES-1:0]  head_wstrb;
    logic               head_we;

    // Cache sees only the FIFO head, so addr/wdata/wstrb cannot move until it pops.
    assign push       = bus.req_valid & ~fifo_full;
    assign pop        = ~fifo_empty & bus.ready;
    assign entry_in   = {bus.req_addr, bus.req_wdata, bus.req_wstrb};
    assign head_wstrb = head[STRB_LSB +: NBYTES];
    assign head_we    = |head_wstrb;

    assign bus.req_ready = ~fifo_full;
    assign bus.valid     = ~fifo_empty;
    assign bus.busy      = ~fifo_empty;
    assign bus.addr      = head[ADDR_LSB +: WADDR_W];
    assign bus.wdata     = head[WDATA_LSB +: DATA_W];
    assign bus.wstrb     = head_wstrb;

    iob_cache_req_fifo #(
        .WIDTH   (REQ_W),
        .DEPTH_W (DEPTH_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (entry_in),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef IOB_CACHE_REQ_PIPE_RESP_REG_EN
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_we_q, resp_we_d;

    // Capture the completion on the cache handshake; hold data between completions.
    always_comb begin
        resp_valid_d = pop;
        resp_rdata_d = resp_rdata_q;
        resp_we_d    = resp_we_q;
        if (pop) begin
            resp_rdata_d = bus.rdata;
            resp_we_d    = head_we;
        end
    end

    // Response register: completion reaches the CPU one cycle after ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_we_q    <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_we_q    <= resp_we_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_we    = resp_we_q;
`else
    // Zero-latency completion; resp_we is qualified so it stays low outside a completion.
    assign bus.resp_valid = pop;
    assign bus.resp_rdata = bus.rdata;
    assign bus.resp_we    = pop & head_we;
`endif

endmodule

// File: tb/tb_iob_cache_req_pipe.sv
// Directed bench for iob_cache_req_pipe with a small latency-programmable cache model.
// Latency: n/a.
// Backpressure: CPU driver holds requests until req_ready; cache ready from model or manual.
module tb_iob_cache_req_pipe;
    import iob_cache_req_pipe_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int DEPTH_W = 1;
`ifdef IOB_CACHE_REQ_PIPE_RESP_REG_EN
    localparam int RL = 1;
`else
    localparam int RL = 0;
`endif

    logic clk;
    logic reset;

    iob_cache_req_pipe_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    iob_cache_req_pipe #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH_W (DEPTH_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Cache model / manual cache drive
    logic        cache_en;
    int          lat;
    int          w;
    logic        model_ready, man_ready;
    logic [31:0] model_rdata, man_rdata;
    logic [31:0] cmem [0:1023];

    assign bus.ready = cache_en ? model_ready : man_ready;
    assign bus.rdata = cache_en ? model_rdata : man_rdata;

    initial begin
        model_ready = 1'b0;
        model_rdata = '0;
        w = 0;
        forever begin
            @(posedge clk);
            #1;
            if (model_ready) begin
                model_ready = 1'b0;
                w = 0;
            end
            if (cache_en && !reset && bus.valid) begin
                w++;
                if (w >= lat) begin
                    model_ready = 1'b1;
                    model_rdata = cmem[bus.addr[9:0]];
                    if (|bus.wstrb) cmem[bus.addr[9:0]] = bus.wdata;
                end
            end else begin
                w = 0;
            end
        end
    end

    // Monitor
    int          cyc = 0;
    logic [31:0] rq_d [$];
    logic        rq_we [$];
    int          pop_cyc [$];
    int          dly_err = 0, stab_err = 0, bubbles = 0;
    int          occ = 0, max_occ = 0;
    logic        saw_full = 1'b0, mon_arm = 1'b0, seen_valid = 1'b0;
    logic        prev_hold = 1'b0;
    logic [29:0] prev_addr;
    logic [31:0] prev_wdata;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset) begin
            occ = 0;
            pop_cyc.delete();
            prev_hold = 1'b0;
        end else begin
            if (bus.valid && bus.ready) pop_cyc.push_back(cyc);
            if (bus.resp_valid) begin
                rq_d.push_back(bus.resp_rdata);
                rq_we.push_back(bus.resp_we);
                if (pop_cyc.size() == 0) dly_err++;
                else if (cyc - pop_cyc.pop_front() != RL) dly_err++;
            end
            occ = occ + int'(bus.req_valid && bus.req_ready) - int'(bus.valid && bus.ready);
            if (occ > max_occ) max_occ = occ;
            if (!bus.req_ready) saw_full = 1'b1;
            if (prev_hold && (!bus.valid || bus.addr != prev_addr || bus.wdata != prev_wdata))
                stab_err++;
            prev_hold  = bus.valid && !bus.ready;
            prev_addr  = bus.addr;
            prev_wdata = bus.wdata;
            if (mon_arm) begin
                if (bus.valid) seen_valid = 1'b1;
                else if (seen_valid && rq_d.size() < 20) bubbles++;
            end
        end
    end

    // Present one request and hold it until accepted; call at posedge+1, returns at posedge+1.
    task automatic send(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
        int   t;
        logic acc;
        t   = 0;
        acc = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            #1;
            t++;
        end
        bus.req_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'(acc), 64'(1));
    endtask

    task automatic clear_mon();
        rq_d.delete();
        rq_we.delete();
        max_occ  = occ;
        saw_full = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int t;
        reset         = 1'b1;
        cache_en      = 1'b0;
        lat           = 1;
        man_ready     = 1'b0;
        man_rdata     = '0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;

        // 1: reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",      64'(bus.valid),      64'(0));
        chk("rst_req_ready",  64'(bus.req_ready),  64'(1));
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        chk("rst_busy",       64'(bus.busy),       64'(0));
        chk("rst_resp_we",    64'(bus.resp_we),    64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // 2: single write, ready after 3 cycles
        cache_en = 1'b1;
        lat      = 3;
        clear_mon();
        send(30'd4, 32'hDEAD, 4'hF);
        @(negedge clk);
        chk("t2_valid",  64'(bus.valid), 64'(1));
        chk("t2_addr",   64'(bus.addr),  64'(4));
        chk("t2_wdata",  64'(bus.wdata), 64'(32'hDEAD));
        chk("t2_wstrb",  64'(bus.wstrb), 64'(4'hF));
        chk("t2_busy",   64'(bus.busy),  64'(1));
        @(negedge clk);
        chk("t2_hold_valid", 64'(bus.valid), 64'(1));
        chk("t2_hold_addr",  64'(bus.addr),  64'(4));
        chk("t2_hold_wdata", 64'(bus.wdata), 64'(32'hDEAD));
        @(negedge clk);
        chk("t2_ready",      64'(bus.ready),      64'(1));
        chk("t2_resp_valid", 64'(bus.resp_valid), 64'(RL == 0));
        chk("t2_resp_we",    64'(bus.resp_we),    64'(RL == 0));
        @(negedge clk);
        chk("t2_busy_after",  64'(bus.busy),       64'(0));
        chk("t2_resp_late",   64'(bus.resp_valid), 64'(RL == 1));
        chk("t2_resp_we_late",64'(bus.resp_we),    64'(RL == 1));
        chk("t2_nresp",       64'(rq_d.size()),    64'(1));
        @(posedge clk); #1;

        // 3: burst of 10 writes then 10 reads
        lat = 2;
        clear_mon();
        seen_valid = 1'b0;
        bubbles    = 0;
        mon_arm    = 1'b1;
        for (int i = 0; i < 10; i++) send(30'(i), 32'(i), 4'hF);
        for (int i = 0; i < 10; i++) send(30'(i), 32'h0, 4'h0);
        t = 0;
        while (rq_d.size() < 20 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        mon_arm = 1'b0;
        chk("t3_nresp", 64'(rq_d.size()), 64'(20));
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t3_wr_we_%0d", i), 64'(rq_we[i]), 64'(1));
        end
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t3_rd_we_%0d", i),    64'(rq_we[10+i]), 64'(0));
            chk($sformatf("t3_rd_data_%0d", i),  64'(rq_d[10+i]),  64'(i));
        end
        chk("t3_bubbles", 64'(bubbles),  64'(0));
        chk("t3_full",    64'(saw_full), 64'(1));
        chk("t3_max_occ", 64'(max_occ),  64'(2));
        repeat (3) @(posedge clk);
        #1;

        // 4: full plus pop in the same cycle does not accept
        cache_en  = 1'b0;
        man_ready = 1'b0;
        clear_mon();
        send(30'd100, 32'h0, 4'h0);
        send(30'd101, 32'h0, 4'h0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 30'd102;
        bus.req_wdata = 32'h0;
        bus.req_wstrb = 4'h0;
        man_ready     = 1'b1;
        man_rdata     = 32'h55;
        @(negedge clk);
        chk("t4_full_rdy", 64'(bus.req_ready), 64'(0));
        chk("t4_head0",    64'(bus.addr),      64'(100));
        @(posedge clk); #1;
        man_ready = 1'b0;
        man_rdata = 32'h66;
        @(negedge clk);
        chk("t4_rdy_next", 64'(bus.req_ready), 64'(1));
        chk("t4_head1",    64'(bus.addr),      64'(101));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        man_ready     = 1'b1;
        @(negedge clk);
        chk("t4_full_again", 64'(bus.req_ready), 64'(0));
        chk("t4_head1_hold", 64'(bus.addr),      64'(101));
        @(posedge clk); #1;
        man_rdata = 32'h77;
        @(negedge clk);
        chk("t4_head2", 64'(bus.addr), 64'(102));
        @(posedge clk); #1;
        man_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_busy",    64'(bus.busy),    64'(0));
        chk("t4_max_occ", 64'(max_occ),     64'(2));
        chk("t4_nresp",   64'(rq_d.size()), 64'(3));
        chk("t4_rdata0",  64'(rq_d[0]),     64'(32'h55));
        chk("t4_rdata1",  64'(rq_d[1]),     64'(32'h66));
        chk("t4_rdata2",  64'(rq_d[2]),     64'(32'h77));
        @(posedge clk); #1;

        // 5: stray ready with FIFO empty
        clear_mon();
        man_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t5_valid_%0d", i), 64'(bus.valid), 64'(0));
        end
        @(posedge clk); #1;
        man_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_nresp", 64'(rq_d.size()), 64'(0));
        chk("t5_busy",  64'(bus.busy),    64'(0));
        @(posedge clk); #1;
        send(30'd200, 32'h1234, 4'h3);
        @(negedge clk);
        chk("t5_head_addr",  64'(bus.addr),  64'(200));
        chk("t5_head_wdata", 64'(bus.wdata), 64'(32'h1234));
        chk("t5_head_wstrb", 64'(bus.wstrb), 64'(4'h3));
        @(posedge clk); #1;
        man_ready = 1'b1;
        @(negedge clk);
        chk("t5_resp_valid", 64'(bus.resp_valid), 64'(RL == 0));
        chk("t5_resp_we",    64'(bus.resp_we),    64'(RL == 0));
        @(posedge clk); #1;
        man_ready = 1'b0;
        @(negedge clk);
        chk("t5_busy_after", 64'(bus.busy), 64'(0));
        @(posedge clk); #1;

        // 6: reset with two entries queued
        send(30'd300, 32'h0, 4'hF);
        send(30'd301, 32'h0, 4'h0);
        clear_mon();
        reset = 1'b1;
        @(negedge clk);
        chk("t6_valid",      64'(bus.valid),      64'(0));
        chk("t6_busy",       64'(bus.busy),       64'(0));
        chk("t6_resp_valid", 64'(bus.resp_valid), 64'(0));
        chk("t6_req_ready",  64'(bus.req_ready),  64'(1));
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_nresp",       64'(rq_d.size()), 64'(0));
        chk("t6_valid_after", 64'(bus.valid),   64'(0));

        chk("resp_delay", 64'(dly_err),  64'(0));
        chk("stability",  64'(stab_err), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
